i2s_rx_frame_ctrl: RTL and testbench

//  Sequences sample capture from the i2s_rx core into a buffered, windowed stream for the ML front end.

---
 rtl/i2s_rx_pkg.sv | 9 +
 rtl/i2s_rx_frame_ctrl_if.sv | 20 ++
 rtl/i2s_rx_fifo.sv | 37 +++
 rtl/i2s_rx_frame_ctrl.sv | 85 ++++++++
 tb/tb_i2s_rx_frame_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared FSM states, channel-mode codes and frame bit positions.
package i2s_rx_pkg;
  typedef enum logic [1:0] {IDLE, ARM, CAP, PUSH_HI} state_t;
  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_STEREO = 2'b10;
  localparam int LEFT_LSB  = 0;
  localparam int RIGHT_LSB = 32;
endpackage

// File: rtl/i2s_rx_frame_ctrl_if.sv
// i2s_rx_frame_ctrl_if: capture controls, frame input and FIFO read/status bundle.
interface i2s_rx_frame_ctrl_if #(parameter int DEPTH = 16);
  logic                   en;
  logic [1:0]             mode;
  logic                   ws;
  logic [63:0]            rx_data;
  logic                   pop;
  logic                   ovf_clr;
  logic [31:0]            rd_data;
  logic [$clog2(DEPTH):0] level;
  logic                   empty;
  logic                   full;
  logic                   win_done;
  logic                   overflow;
  logic                   irq;
  modport master (output en, mode, ws, rx_data, pop, ovf_clr,
                  input rd_data, level, empty, full, win_done, overflow, irq);
  modport slave (input en, mode, ws, rx_data, pop, ovf_clr,
                 output rd_data, level, empty, full, win_done, overflow, irq);
endinterface

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: show-ahead synchronous FIFO; a full FIFO still accepts a push paired with a pop.
module i2s_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [AW:0] level,
  output logic        empty,
  output logic        full
);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr, rd;
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign empty = level == '0;
  assign full  = level == (AW+1)'(DEPTH);
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
  // On push+pop while full, the write lands in the slot being vacated.
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/i2s_rx_frame_ctrl.sv
// i2s_rx_frame_ctrl: turns completed I2S frames into a windowed 32-bit word stream in a FIFO.
// Define I2S_RX_FRAME_IRQ_EN to generate irq pulses on window completion and word drops.
module i2s_rx_frame_ctrl
  import i2s_rx_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WINDOW = 256
) (
  input logic              HCLK,
  input logic              HRESET,
  i2s_rx_frame_ctrl_if.slave bus
);
  localparam int CW = $clog2(WINDOW);
  state_t        state;
  logic          ws_q;
  logic [1:0]    mode_l;
  logic [31:0]   hi_q;
  logic [CW-1:0] win_cnt;
  logic          win_done_q, overflow_q;
  logic          strobe, push, drop, win_next;
  logic [31:0]   push_data;
  assign strobe    = ws_q & ~bus.ws;
  assign push      = (state == CAP & bus.en & strobe & mode_l != 2'b11) | state == PUSH_HI;
  assign push_data = state == PUSH_HI      ? hi_q :
                     mode_l == MODE_RIGHT  ? bus.rx_data[RIGHT_LSB +: 32] :
                                             bus.rx_data[LEFT_LSB +: 32];
  assign drop      = push & bus.full & ~bus.pop;
  assign win_next  = push & win_cnt == CW'(WINDOW - 1);
  assign bus.win_done = win_done_q;
  assign bus.overflow = overflow_q;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state  <= IDLE;
      ws_q   <= 1'b0;
      mode_l <= MODE_LEFT;
      hi_q   <= '0;
    end else begin
      ws_q <= bus.ws;
      case (state)
        IDLE: if (bus.en) begin
          state  <= ARM;
          mode_l <= bus.mode;
        end
        ARM: state <= !bus.en ? IDLE : strobe ? CAP : ARM;
        CAP: if (!bus.en) state <= IDLE;
        else if (strobe && mode_l == MODE_STEREO) begin
          state <= PUSH_HI;
          hi_q  <= bus.rx_data[RIGHT_LSB +: 32];
        end
        PUSH_HI: state <= CAP;
        default: state <= IDLE;
      endcase
    end
  // Dropped words still advance the window so window timing follows the audio, not the FIFO.
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      win_cnt    <= '0;
      win_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      win_cnt    <= ((state == CAP & ~bus.en) | win_next) ? '0 : win_cnt + CW'(push);
      win_done_q <= win_next;
      overflow_q <= drop | (overflow_q & ~bus.ovf_clr);
    end
`ifdef I2S_RX_FRAME_IRQ_EN
  logic irq_q;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) irq_q <= 1'b0;
    else irq_q <= win_next | drop;
  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif
  i2s_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .pop   (bus.pop),
    .wdata (push_data),
    .rdata (bus.rd_data),
    .level (bus.level),
    .empty (bus.empty),
    .full  (bus.full)
  );
endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// tb_i2s_rx_frame_ctrl: directed and random frames checked every cycle against a queue-based model.
module tb_i2s_rx_frame_ctrl;
  localparam int DEPTH  = 16;
  localparam int WINDOW = 4;
`ifdef I2S_RX_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int n_cmp = 0, n_err = 0, pop_pct = 0, clr_pct = 0, win_seen = 0;
  i2s_rx_frame_ctrl_if #(.DEPTH(DEPTH)) b ();
  i2s_rx_frame_ctrl #(.DEPTH(DEPTH), .WINDOW(WINDOW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (b)
  );
  always #5 HCLK = ~HCLK;
  // model: capture active, first frame discarded, pending high word, latched mode
  bit          m_act, m_prim, m_pend, m_wsq, m_ovf, m_win, m_irq;
  logic [1:0]  m_mode;
  logic [31:0] m_hi;
  logic [31:0] q[$];
  int          m_cnt;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_reset();
    q.delete();
    m_act = 0; m_prim = 0; m_pend = 0; m_wsq = 0; m_ovf = 0; m_win = 0; m_irq = 0;
    m_mode = 2'b00; m_hi = '0; m_cnt = 0;
  endfunction
  function automatic void model_step();
    bit stb, push, drop;
    logic [31:0] w;
    stb = m_wsq & !b.ws;
    push = 0;
    w = '0;
    if (m_pend) begin
      push = 1; w = m_hi; m_pend = 0;
    end else if (!m_act) begin
      if (b.en) begin m_act = 1; m_prim = 0; m_mode = b.mode; end
    end else if (!b.en) begin
      m_act = 0; m_cnt = 0;
    end else if (stb) begin
      if (!m_prim) m_prim = 1;
      else case (m_mode)
        2'd0: begin push = 1; w = b.rx_data[31:0]; end
        2'd1: begin push = 1; w = b.rx_data[63:32]; end
        2'd2: begin push = 1; w = b.rx_data[31:0]; m_pend = 1; m_hi = b.rx_data[63:32]; end
        default: ;
      endcase
    end
    drop = push && q.size() == DEPTH && !b.pop;
    if (b.pop && q.size() > 0) void'(q.pop_front());
    if (push && !drop) q.push_back(w);
    m_win = 0;
    if (push) begin
      if (m_cnt == WINDOW - 1) begin m_cnt = 0; m_win = 1; end
      else m_cnt++;
    end
    m_ovf = drop ? 1'b1 : (b.ovf_clr ? 1'b0 : m_ovf);
    m_irq = IRQ_EN & (m_win | drop);
    m_wsq = b.ws;
  endfunction
  task automatic check_all();
    check("level", 64'(b.level), 64'(q.size()));
    check("empty", 64'(b.empty), 64'(q.size() == 0));
    check("full", 64'(b.full), 64'(q.size() == DEPTH));
    check("win_done", 64'(b.win_done), 64'(m_win));
    check("overflow", 64'(b.overflow), 64'(m_ovf));
    check("irq", 64'(b.irq), 64'(m_irq));
    if (q.size() > 0) check("rd_data", 64'(b.rd_data), 64'(q[0]));
  endtask
  task automatic cyc(input int p, input bit c);
    b.pop = p < 0 ? ($urandom_range(99) < pop_pct) : p[0];
    b.ovf_clr = c | ($urandom_range(99) < clr_pct);
    @(posedge HCLK);
    model_step();
    @(negedge HCLK);
    check_all();
    win_seen += int'(b.win_done);
  endtask
  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int half, input int ps);
    b.ws = 1'b1;
    repeat (half) cyc(-1, 1'b0);
    b.ws = 1'b0;
    b.rx_data = {r, l};
    cyc(ps, 1'b0);
    repeat (half - 1) cyc(-1, 1'b0);
  endtask
  task automatic do_reset();
    HRESET = 1'b1;
    b.en = 0; b.mode = 0; b.ws = 0; b.rx_data = 0; b.pop = 0; b.ovf_clr = 0;
    pop_pct = 0; clr_pct = 0;
    repeat (2) @(negedge HCLK);
    model_reset();
    HRESET = 1'b0;
    check_all();
    check("rst_rd_data", 64'(b.rd_data), 64'h0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    // left channel, first frame discarded
    do_reset();
    b.mode = 2'b00; b.en = 1'b1;
    for (int i = 1; i <= 3; i++) frame(32'hA5A5_0000 + 32'(i), $urandom, 4, -1);
    check("t1_level", 64'(b.level), 64'd2);
    check("t1_head", 64'(b.rd_data), 64'hA5A5_0002);
    repeat (2) cyc(1, 1'b0);
    // stereo pair
    b.en = 1'b0;
    repeat (2) cyc(-1, 1'b0);
    b.mode = 2'b10; b.en = 1'b1;
    frame($urandom, $urandom, 4, -1);
    frame(32'h1111_1111, 32'h2222_2222, 4, -1);
    check("t2_level", 64'(b.level), 64'd2);
    check("t2_first", 64'(b.rd_data), 64'h1111_1111);
    cyc(1, 1'b0);
    check("t2_second", 64'(b.rd_data), 64'h2222_2222);
    cyc(1, 1'b0);
    // overflow on a full FIFO
    do_reset();
    b.mode = 2'b01; b.en = 1'b1;
    repeat (19) frame($urandom, $urandom, 3, -1);
    check("t3_level", 64'(b.level), 64'd16);
    check("t3_full", 64'(b.full), 64'd1);
    check("t3_ovf", 64'(b.overflow), 64'd1);
    cyc(-1, 1'b1);
    check("t3_ovf_clr", 64'(b.overflow), 64'd0);
    frame($urandom, $urandom, 3, 1);
    check("t3_pushpop_level", 64'(b.level), 64'd16);
    check("t3_pushpop_ovf", 64'(b.overflow), 64'd0);
    // window pulses
    do_reset();
    win_seen = 0;
    b.mode = 2'b00; b.en = 1'b1;
    repeat (10) frame($urandom, $urandom, 3, -1);
    check("t4_wins", 64'(win_seen), 64'd2);
    // en dropped right after a stereo strobe
    do_reset();
    b.mode = 2'b10; b.en = 1'b1;
    frame($urandom, $urandom, 3, -1);
    b.ws = 1'b1;
    repeat (3) cyc(-1, 1'b0);
    b.ws = 1'b0; b.rx_data = {32'hBBBB_0002, 32'hAAAA_0001};
    cyc(-1, 1'b0);
    b.en = 1'b0;
    repeat (3) cyc(-1, 1'b0);
    check("t5_level", 64'(b.level), 64'd2);
    b.mode = 2'b01; b.en = 1'b1;
    frame($urandom, $urandom, 3, -1);
    frame(32'h0, 32'hCCCC_0003, 3, -1);
    check("t5_level2", 64'(b.level), 64'd3);
    check("t5_head", 64'(b.rd_data), 64'hAAAA_0001);
    // asynchronous reset mid-capture
    do_reset();
    b.mode = 2'b00; b.en = 1'b1;
    repeat (6) frame($urandom, $urandom, 3, -1);
    check("t6_pre_level", 64'(b.level), 64'd5);
    #2 HRESET = 1'b1;
    #1;
    check("t6_level", 64'(b.level), 64'd0);
    check("t6_empty", 64'(b.empty), 64'd1);
    check("t6_full", 64'(b.full), 64'd0);
    check("t6_rd_data", 64'(b.rd_data), 64'd0);
    check("t6_ovf", 64'(b.overflow), 64'd0);
    check("t6_win", 64'(b.win_done), 64'd0);
    check("t6_irq", 64'(b.irq), 64'd0);
    do_reset();
    // randomized traffic
    b.en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i % 10 == 0) begin
        case ($urandom_range(2))
          0: pop_pct = 0;
          1: pop_pct = 5;
          default: pop_pct = 30;
        endcase
        clr_pct = 2;
      end
      if ($urandom_range(9) == 0) b.en = ~b.en;
      b.mode = 2'($urandom_range(3));
      frame($urandom, $urandom, $urandom_range(3, 6), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
